// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 keypad matrix scanner with press/release debounce.
// Drives one row low at a time, locks onto the first closed key found, debounces it,
// and emits a single-cycle strobe with the mapped key code once per physical press.
`timescale 1ns/1ps

module keypad_scan_ctrl #(
  parameter int unsigned SCAN_CYCLES     = 4096,
  parameter int unsigned DEBOUNCE_CYCLES = 65536
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_keys,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       busy
);

  localparam int unsigned DwellW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int unsigned DbW    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DwellW-1:0] DwellLast = DwellW'(SCAN_CYCLES - 1);
  localparam logic [DbW-1:0]    DbLast    = DbW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {StScan, StDebPress, StHeld} state_e;

  state_e            state_q;
  logic [DwellW-1:0] dwell_q;
  logic [DbW-1:0]    db_q;
  logic [1:0]        col_sel_q;

  logic [1:0] row_idx;
  logic [1:0] low_col;
  logic       any_low;
  logic       sel_bit;
  logic [3:0] row_next;
  logic [3:0] mapped_code;

  // Key legend indexed by {row, column}.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Row index decode, lowest-low column priority, and the locked column's level.
  always_comb begin
    row_idx = 2'd3;
    case (row)
      4'b1110: row_idx = 2'd0;
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      default: row_idx = 2'd3;
    endcase

    low_col = 2'd3;
    if (!col_keys[0])      low_col = 2'd0;
    else if (!col_keys[1]) low_col = 2'd1;
    else if (!col_keys[2]) low_col = 2'd2;

    any_low     = ~&col_keys;
    sel_bit     = col_keys[col_sel_q];
    row_next    = {row[2:0], row[3]};
    mapped_code = key_map(row_idx, col_sel_q);
  end

  // Scan / debounce / held sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StScan;
      dwell_q   <= '0;
      db_q      <= '0;
      col_sel_q <= 2'd0;
      row       <= 4'b1110;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      unique case (state_q)
        StScan: begin
          // Columns are only trusted at the end of the dwell, after the row has settled.
          if (dwell_q == DwellLast) begin
            dwell_q <= '0;
            if (any_low) begin
              col_sel_q <= low_col;
              db_q      <= '0;
              state_q   <= StDebPress;
            end else begin
              row <= row_next;
            end
          end else begin
            dwell_q <= dwell_q + 1'b1;
          end
        end
        StDebPress: begin
          if (sel_bit) begin
            // Bounce: drop the candidate and move on as if the row were idle.
            db_q    <= '0;
            dwell_q <= '0;
            row     <= row_next;
            state_q <= StScan;
          end else if (db_q == DbLast) begin
            key_code  <= mapped_code;
            key_valid <= 1'b1;
            db_q      <= '0;
            state_q   <= StHeld;
          end else begin
            db_q <= db_q + 1'b1;
          end
        end
        StHeld: begin
          if (!sel_bit) begin
            db_q <= '0;
          end else if (db_q == DbLast) begin
            db_q    <= '0;
            dwell_q <= '0;
            row     <= row_next;
            state_q <= StScan;
          end else begin
            db_q <= db_q + 1'b1;
          end
        end
        default: state_q <= StScan;
      endcase
    end
  end

  assign busy = (state_q != StScan);

endmodule
